dcache_assoc: RTL and testbench
===============================

DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter LINE_BYTES, default 32: line size in bytes, a power of two of at least 4.
REQ-003 SHALL have parameter SETS, default 32: number of sets, a power of two of at least 2; associativity is fixed at 2 ways.
REQ-004 SHALL have port clk_i, input, 1 bit: clock.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port mem_data_i, input, LINE_BYTES*8 bits: fill line from memory.
REQ-007 SHALL have port mem_ack_i, input, 1 bit: memory completion, a one-cycle pulse.
REQ-008 SHALL have port mem_data_o, output, LINE_BYTES*8 bits: write-back line.
REQ-009 SHALL have port mem_addr_o, output, ADDR_W bits: line-aligned memory address.
REQ-010 SHALL have port mem_enable_o, output, 1 bit: memory request.
REQ-011 SHALL have port mem_write_o, output, 1 bit: 1 = write-back, 0 = fill.
REQ-012 SHALL have port p1_addr_i, input, ADDR_W bits: CPU byte address; bits [1:0] are ignored.
REQ-013 SHALL have port p1_data_i, input, 32 bits: CPU store data.
REQ-014 SHALL have port p1_be_i, input, 4 bits: store byte enables.
REQ-015 SHALL have ports p1_MemRead_i and p1_MemWrite_i, input, 1 bit each: CPU read and write requests.
REQ-016 SHALL have port p1_data_o, output, 32 bits: load data.
REQ-017 SHALL have port p1_stall_o, output, 1 bit: CPU stall.

Function
REQ-018 SHALL split the address as offset = low log2(LINE_BYTES) bits, index = next log2(SETS) bits, tag = remaining bits.
REQ-019 SHALL hold per way and set: a valid bit, a dirty bit, a tag and a line; and per set: one replacement bit.
REQ-020 SHALL define req = p1_MemRead_i | p1_MemWrite_i, and treat req with both bits set as a write.
REQ-021 SHALL define hit = req & state IDLE & (valid & tag match in way 0 or in way 1); a fill never creates a duplicate tag within a set.
REQ-022 SHALL drive p1_stall_o = req & ~hit, combinationally.
REQ-023 SHALL drive p1_data_o with the addressed word of the hitting way, combinationally, and 0 when there is no hit.
REQ-024 SHALL, on a write hit at the clock edge, merge the bytes of p1_data_i selected by p1_be_i into the line and set its dirty bit.
REQ-025 SHALL use states IDLE, WB, FILL and FILLOK.
REQ-026 SHALL, in IDLE with req & ~hit, choose a victim way, latch the victim way, index and request tag, and set mem_enable_o=1.
- Victim choice: an invalid way first (way 0 if both are invalid); otherwise the way named by the replacement bit.
REQ-027 SHALL, on leaving IDLE, go to WB if the victim is valid & dirty (mem_write_o=1), else to FILL (mem_write_o=0).
REQ-028 SHALL, in WB, drive mem_addr_o = {victim tag, index, 0} and mem_data_o = victim line.
- On mem_ack_i: set mem_write_o=0 and go to FILL, keeping mem_enable_o=1.
REQ-029 SHALL, in FILL, drive mem_addr_o = {request tag, index, 0}.
- On mem_ack_i: write mem_data_i into the victim way with valid=1, dirty=0 and tag = request tag; clear mem_enable_o; go to FILLOK.
REQ-030 SHALL go from FILLOK to IDLE unconditionally.
- The request then hits in the next cycle and a pending write merges on that cycle's edge.
REQ-031 SHALL register mem_enable_o and mem_write_o, and drive mem_data_o to 0 outside WB.
REQ-032 SHALL give a clean-miss latency of: request cycle N, mem_enable_o high from N+1, ack at cycle M, stall low at cycle M+2.
REQ-033 SHALL ignore mem_ack_i in IDLE and FILLOK.
REQ-034 SHALL require the CPU to hold p1_* stable while p1_stall_o=1; behaviour is unspecified otherwise.
REQ-035 SHALL leave p1_data_o, the tags and the line data uninitialised by reset.

Reset
REQ-036 SHALL, while rst_i=0, immediately force: state IDLE, mem_enable_o=0, mem_write_o=0, all valid, dirty and replacement bits 0.
REQ-037 SHALL, on reset asserted mid-WB or mid-FILL, abandon the memory transaction without updating any cache line.

Configuration
REQ-038 SHALL, with DCACHE_LRU_EN defined, keep the replacement bit pointing at the least-recently-used way, updated on every hit and every fill to name the other way.
REQ-039 SHALL, without DCACHE_LRU_EN, toggle the replacement bit only on fills (per-set round-robin) and leave it unchanged on hits.

Verification
REQ-040 SHALL check: reset; read 0x00000000; memory line word0 0xDEADBEEF, ack 3 cycles after enable -> mem_write_o never 1, stall drops at ack+2, p1_data_o=0xDEADBEEF.
REQ-041 SHALL check: line at 0x00000000 holding word1 0xAABBCCDD; write 0x00000004 data 0x11223344 be 0011 -> no stall; next read returns 0xAABB3344.
REQ-042 SHALL check: fill 0x000 then 0x400 (both index 0) -> re-reads of both hit with zero stall, no memory request.
REQ-043 SHALL check: write 0x000 (dirty), fill 0x400, read 0x000, read 0x800.
- With DCACHE_LRU_EN: 0x400 is evicted with no WB.
- Without DCACHE_LRU_EN: WB of the line to mem_addr_o=0x000, then a fill from 0x800.
REQ-044 SHALL check: rst_i=0 during FILL while mem_enable_o=1 -> mem_enable_o=0 immediately; after release, the same read misses again and refills.

Source files
------------

// File: rtl/dcache_assoc_if.sv
// Memory-side bus of the 2-way data cache: line fill / write-back handshake.
// The cache is the master (issues requests), the memory is the slave.
interface dcache_assoc_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32
);
    logic [LINE_BYTES*8-1:0] mem_data_i;
    logic                    mem_ack_i;
    logic [LINE_BYTES*8-1:0] mem_data_o;
    logic [ADDR_W-1:0]       mem_addr_o;
    logic                    mem_enable_o;
    logic                    mem_write_o;

    modport master (
        input  mem_data_i, mem_ack_i,
        output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
    );

    modport slave (
        output mem_data_i, mem_ack_i,
        input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
    );
endinterface

// File: rtl/dcache_assoc.sv
// 2-way set-associative write-back data cache with a blocking miss FSM
// (IDLE -> [WB] -> FILL -> FILLOK). Replacement is per-set round-robin by
// default; defining DCACHE_LRU_EN switches it to true LRU.
module dcache_assoc #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int SETS       = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dcache_assoc_if.master      mem,
    input  logic [ADDR_W-1:0]   p1_addr_i,
    input  logic [31:0]         p1_data_i,
    input  logic [3:0]          p1_be_i,
    input  logic                p1_MemRead_i,
    input  logic                p1_MemWrite_i,
    output logic [31:0]         p1_data_o,
    output logic                p1_stall_o
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int POS_W  = OFF_W + 3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WB     = 2'd1;
    localparam logic [1:0] S_FILL   = 2'd2;
    localparam logic [1:0] S_FILLOK = 2'd3;

    logic [1:0]        r_state;
    logic              r_mem_enable;
    logic              r_mem_write;
    logic [SETS-1:0]   r_valid [2];
    logic [SETS-1:0]   r_dirty [2];
    logic [SETS-1:0]   r_repl;
    logic [TAG_W-1:0]  r_tag   [2][SETS];
    logic [LINE_W-1:0] r_line  [2][SETS];
    logic              r_vway;
    logic [IDX_W-1:0]  r_vidx;
    logic [TAG_W-1:0]  r_req_tag;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [POS_W-1:0]  w_pos;
    logic              w_req;
    logic              w_hit0;
    logic              w_hit1;
    logic              w_hit;
    logic              w_hit_way;
    logic              w_wr_hit;
    logic              w_miss;
    logic              w_victim;
    logic              w_victim_wb;
    logic              w_fill_done;
    logic [LINE_W-1:0] w_hit_line;
    logic [31:0]       w_hit_word;
    logic [31:0]       w_merged_word;
    logic [LINE_W-1:0] w_merged_line;

    assign w_idx = p1_addr_i[OFF_W +: IDX_W];
    assign w_tag = p1_addr_i[ADDR_W-1 -: TAG_W];
    // Bit position of the addressed 32-bit word; address bits [1:0] are dropped.
    assign w_pos = {p1_addr_i[OFF_W-1:0] & ~OFF_W'(3), 3'b000};

    assign w_req     = p1_MemRead_i | p1_MemWrite_i;
    assign w_hit0    = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1    = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit     = w_req && (r_state == S_IDLE) && (w_hit0 || w_hit1);
    // Fills never duplicate a tag in a set, so way 1 matching identifies the way.
    assign w_hit_way = w_hit1;
    assign w_wr_hit  = w_hit && p1_MemWrite_i;
    assign w_miss    = w_req && (r_state == S_IDLE) && !w_hit;

    assign w_hit_line = r_line[w_hit_way][w_idx];
    assign w_hit_word = w_hit_line[w_pos +: 32];

    assign p1_data_o  = w_hit ? w_hit_word : 32'd0;
    assign p1_stall_o = w_req && !w_hit;

    // Invalid ways are filled first, way 0 before way 1.
    assign w_victim    = !r_valid[0][w_idx] ? 1'b0 :
                         !r_valid[1][w_idx] ? 1'b1 : r_repl[w_idx];
    assign w_victim_wb = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];
    assign w_fill_done = (r_state == S_FILL) && mem.mem_ack_i;

    assign mem.mem_enable_o = r_mem_enable;
    assign mem.mem_write_o  = r_mem_write;
    assign mem.mem_addr_o   = (r_state == S_WB) ?
                              {r_tag[r_vway][r_vidx], r_vidx, {OFF_W{1'b0}}} :
                              {r_req_tag, r_vidx, {OFF_W{1'b0}}};
    assign mem.mem_data_o   = (r_state == S_WB) ? r_line[r_vway][r_vidx] : '0;

    // Store merge: replace the enabled bytes of the addressed word in the hit line.
    always_comb begin
        w_merged_word = w_hit_word;
        for (int b = 0; b < 4; b++) begin
            if (p1_be_i[b]) w_merged_word[8*b +: 8] = p1_data_i[8*b +: 8];
        end
        w_merged_line = w_hit_line;
        w_merged_line[w_pos +: 32] = w_merged_word;
    end

    // Miss FSM, memory request flags and per-line valid/dirty/replacement state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_valid[0]   <= '0;
            r_valid[1]   <= '0;
            r_dirty[0]   <= '0;
            r_dirty[1]   <= '0;
            r_repl       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_mem_enable <= 1'b1;
                        r_mem_write  <= w_victim_wb;
                        r_state      <= w_victim_wb ? S_WB : S_FILL;
                    end else if (w_hit) begin
                        if (p1_MemWrite_i) r_dirty[w_hit_way][w_idx] <= 1'b1;
`ifdef DCACHE_LRU_EN
                        r_repl[w_idx] <= ~w_hit_way;
`endif
                    end
                end
                S_WB: begin
                    if (mem.mem_ack_i) begin
                        r_mem_write <= 1'b0;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem.mem_ack_i) begin
                        r_valid[r_vway][r_vidx] <= 1'b1;
                        r_dirty[r_vway][r_vidx] <= 1'b0;
                        r_mem_enable            <= 1'b0;
                        r_state                 <= S_FILLOK;
`ifdef DCACHE_LRU_EN
                        r_repl[r_vidx] <= ~r_vway;
`else
                        r_repl[r_vidx] <= ~r_repl[r_vidx];
`endif
                    end
                end
                S_FILLOK: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Tag/line arrays and the latched miss context; not reset. A reset mid-miss
    // forces IDLE, which blocks the fill write, so no line is touched.
    always_ff @(posedge clk_i) begin
        if (w_miss) begin
            r_vway    <= w_victim;
            r_vidx    <= w_idx;
            r_req_tag <= w_tag;
        end
        if (w_fill_done) begin
            r_tag[r_vway][r_vidx]  <= r_req_tag;
            r_line[r_vway][r_vidx] <= mem.mem_data_i;
        end else if (w_wr_hit) begin
            r_line[w_hit_way][w_idx] <= w_merged_line;
        end
    end
endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc: directed scenarios followed by random traffic,
// scored against an architectural memory image plus a residency model.
module tb_dcache_assoc;
    localparam int ADDR_W     = 32;
    localparam int LINE_BYTES = 32;
    localparam int SETS       = 32;
    localparam int WPL        = LINE_BYTES / 4;
    localparam int LINE_W     = LINE_BYTES * 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] p1_addr_i;
    logic [31:0] p1_data_i;
    logic [3:0]  p1_be_i;
    logic        p1_MemRead_i;
    logic        p1_MemWrite_i;
    logic [31:0] p1_data_o;
    logic        p1_stall_o;

    dcache_assoc_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES)) mem_if ();

    dcache_assoc #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .SETS(SETS)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem           (mem_if.master),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_be_i       (p1_be_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural memory (what the CPU must observe) and backing memory.
    logic [31:0] arch [logic [31:0]];
    logic [31:0] bmem [logic [31:0]];

    // Residency model: which line tags sit in which way of a set.
    int unsigned m_tag   [SETS][2];
    bit          m_val   [SETS][2];
    bit          m_dirty [SETS][2];
    longint      m_used  [SETS][2];
    int          m_fills [SETS];
    longint      now_t = 0;

    // Results of the last access.
    logic [31:0] a_rdata;
    int          a_cycles, a_n_wb, a_n_fill, a_en_first;
    logic [31:0] a_wb_addr, a_fill_addr;
    bit          a_en_seen, a_wr_seen, a_timeout;

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] wa);
        if (arch.exists(wa)) return arch[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        if (bmem.exists(wa)) return bmem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [LINE_W-1:0] line_of(input bit from_mem, input logic [31:0] baddr);
        logic [LINE_W-1:0] l;
        logic [31:0] wa0;
        wa0 = (baddr >> 2) & ~32'(WPL - 1);
        for (int i = 0; i < WPL; i++)
            l[i*32 +: 32] = from_mem ? mem_rd(wa0 + 32'(i)) : arch_rd(wa0 + 32'(i));
        return l;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkl(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset empties the cache; dirty data it held is lost architecturally.
    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < 2; w++) begin
                if (m_val[s][w] && m_dirty[s][w]) begin
                    for (int i = 0; i < WPL; i++) begin
                        logic [31:0] wa;
                        wa = 32'((m_tag[s][w] * SETS + s) * WPL + i);
                        arch[wa] = mem_rd(wa);
                    end
                end
                m_val[s][w]   = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_used[s][w]  = 0;
            end
            m_fills[s] = 0;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        mem_if.mem_ack_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    // One CPU access, entered at posedge+1; memory answers d cycles after enable.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be, input int d);
        int cnt;
        logic [31:0] wa0;
        cnt = 0;
        a_cycles = 0; a_n_wb = 0; a_n_fill = 0; a_en_first = -1;
        a_en_seen = 1'b0; a_wr_seen = 1'b0; a_timeout = 1'b0;
        a_wb_addr = '0; a_fill_addr = '0; a_rdata = '0;
        p1_addr_i = addr; p1_data_i = data; p1_be_i = be;
        p1_MemRead_i = rd; p1_MemWrite_i = wr;
        #1;
        forever begin
            if (mem_if.mem_enable_o === 1'b1) begin
                a_en_seen = 1'b1;
                if (a_en_first < 0) a_en_first = a_cycles;
                if (mem_if.mem_write_o === 1'b1) a_wr_seen = 1'b1;
            end
            if (p1_stall_o !== 1'b1) break;
            if (a_cycles >= 100) begin
                a_timeout = 1'b1;
                break;
            end
            if (mem_if.mem_enable_o === 1'b1) begin
                if (cnt == d) begin
                    cnt = 0;
                    mem_if.mem_ack_i = 1'b1;
                    if (mem_if.mem_write_o === 1'b1) begin
                        a_n_wb++;
                        a_wb_addr = mem_if.mem_addr_o;
                        chkl("wb.data", mem_if.mem_data_o, line_of(1'b0, a_wb_addr));
                        wa0 = (a_wb_addr >> 2) & ~32'(WPL - 1);
                        for (int i = 0; i < WPL; i++)
                            bmem[wa0 + 32'(i)] = mem_if.mem_data_o[i*32 +: 32];
                    end else begin
                        a_n_fill++;
                        a_fill_addr = mem_if.mem_addr_o;
                        chkl("fill.mem_data_o", mem_if.mem_data_o, '0);
                        mem_if.mem_data_i = line_of(1'b1, a_fill_addr);
                    end
                end else begin
                    cnt++;
                end
            end
            @(posedge clk_i);
            #1;
            mem_if.mem_ack_i = 1'b0;
            a_cycles++;
            #1;
        end
        a_rdata = p1_data_o;
        @(posedge clk_i);
        #1;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    // Access with expectations derived from the residency model and arch image.
    task automatic access_chk(input string tg, input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] be, input int d);
        int s, v;
        int unsigned ln, t;
        bit hit, exp_wb;
        logic [31:0] exp_wb_addr, exp_data, wa;
        ln = addr / LINE_BYTES;
        s  = int'(ln % SETS);
        t  = ln / SETS;
        wa = addr >> 2;
        hit = 1'b0;
        v = 0;
        for (int w = 0; w < 2; w++)
            if (m_val[s][w] && m_tag[s][w] == t) begin hit = 1'b1; v = w; end
        if (!hit) begin
            if (!m_val[s][0]) v = 0;
            else if (!m_val[s][1]) v = 1;
            else begin
`ifdef DCACHE_LRU_EN
                v = (m_used[s][0] < m_used[s][1]) ? 0 : 1;
`else
                v = m_fills[s] % 2;
`endif
            end
        end
        exp_wb      = !hit && m_val[s][v] && m_dirty[s][v];
        exp_wb_addr = (m_tag[s][v] * SETS + s) * LINE_BYTES;
        exp_data    = arch_rd(wa);

        access(rd, wr, addr, data, be, d);

        chk1({tg, ".timeout"}, a_timeout, 1'b0);
        chk1({tg, ".hit"}, a_cycles == 0, hit);
        if (hit) begin
            chk1({tg, ".nomemreq"}, a_en_seen, 1'b0);
        end else begin
            chk32({tg, ".wbcount"}, a_n_wb, exp_wb ? 1 : 0);
            if (exp_wb) chk32({tg, ".wbaddr"}, a_wb_addr, exp_wb_addr);
            chk32({tg, ".fillcount"}, a_n_fill, 1);
            chk32({tg, ".filladdr"}, a_fill_addr, ln * LINE_BYTES);
            chk32({tg, ".latency"}, a_cycles, exp_wb ? 4 + 2*d : 3 + d);
            chk32({tg, ".enfirst"}, a_en_first, 1);
        end
        chk32({tg, ".data"}, a_rdata, exp_data);

        if (!hit) begin
            m_val[s][v]   = 1'b1;
            m_tag[s][v]   = t;
            m_dirty[s][v] = 1'b0;
            m_fills[s]++;
        end
        now_t++;
        m_used[s][v] = now_t;
        if (wr) begin
            m_dirty[s][v] = 1'b1;
            arch[wa] = merge(exp_data, data, be);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        p1_addr_i = '0; p1_data_i = '0; p1_be_i = '0;
        p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
        mem_if.mem_ack_i = 1'b0;
        mem_if.mem_data_i = '0;
        model_reset();

        // Reset state, with a read request held during reset.
        #1 rst_i = 1'b0;
        #1;
        chk1("rst.enable", mem_if.mem_enable_o, 1'b0);
        chk1("rst.write", mem_if.mem_write_o, 1'b0);
        chk1("rst.stall_on_req", p1_stall_o, 1'b1);
        chk32("rst.data_o", p1_data_o, 32'd0);
        chkl("rst.mem_data_o", mem_if.mem_data_o, '0);
        @(posedge clk_i);
        #1;
        chk1("rst.enable_held", mem_if.mem_enable_o, 1'b0);
        p1_MemRead_i = 1'b0;
        #1;
        chk1("rst.stall_noreq", p1_stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Clean read miss, memory acks 3 cycles after enable.
        bmem[32'd0] = 32'hDEADBEEF; arch[32'd0] = 32'hDEADBEEF;
        bmem[32'd1] = 32'hAABBCCDD; arch[32'd1] = 32'hAABBCCDD;
        access_chk("r040", 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 3);
        chk32("r040.data_const", a_rdata, 32'hDEADBEEF);
        chk1("r040.no_write", a_wr_seen, 1'b0);
        chk32("r040.stall_drop", a_cycles, 32'd6);

        // Partial store hit, then read back the merged word.
        access_chk("r041w", 1'b0, 1'b1, 32'h4, 32'h11223344, 4'b0011, 1);
        chk32("r041w.nostall", a_cycles, 32'd0);
        access_chk("r041r", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1);
        chk32("r041r.data_const", a_rdata, 32'hAABB3344);

        // Two lines of the same set coexist.
        access_chk("r042f", 1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 2);
        access_chk("r042a", 1'b1, 1'b0, 32'h000, 32'h0, 4'h0, 2);
        chk32("r042a.nostall", a_cycles, 32'd0);
        access_chk("r042b", 1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 2);
        chk1("r042b.nomem", a_en_seen, 1'b0);

        // Replacement choice on a third conflicting line.
        do_reset();
        access_chk("r043w", 1'b0, 1'b1, 32'h000, 32'h0BADF00D, 4'hF, 1);
        access_chk("r043f", 1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 1);
        access_chk("r043a", 1'b1, 1'b0, 32'h000, 32'h0, 4'h0, 1);
        access_chk("r043b", 1'b1, 1'b0, 32'h800, 32'h0, 4'h0, 2);
`ifdef DCACHE_LRU_EN
        chk32("r043b.lru_nowb", a_n_wb, 32'd0);
`else
        chk32("r043b.rr_wb", a_n_wb, 32'd1);
        chk32("r043b.rr_wbaddr", a_wb_addr, 32'h000);
`endif
        chk32("r043b.filladdr_const", a_fill_addr, 32'h800);
        access_chk("r043c", 1'b1, 1'b0, 32'h000, 32'h0, 4'h0, 1);
        chk32("r043c.data_const", a_rdata, 32'h0BADF00D);

        // Reset asserted while a fill is outstanding.
        do_reset();
        p1_addr_i = 32'h1000;
        p1_MemRead_i = 1'b1;
        #1;
        chk1("r044.miss", p1_stall_o, 1'b1);
        @(posedge clk_i);
        #2;
        chk1("r044.enable", mem_if.mem_enable_o, 1'b1);
        chk1("r044.fill", mem_if.mem_write_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk1("r044.async_enable", mem_if.mem_enable_o, 1'b0);
        chk1("r044.async_write", mem_if.mem_write_o, 1'b0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        access_chk("r044re", 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 2);
        chk32("r044re.refill", a_n_fill, 32'd1);

        // Random traffic over a few conflicting tags in two sets.
        for (int n = 0; n < 300; n++) begin
            int op;
            logic [31:0] addr;
            op   = int'($urandom_range(0, 3));
            addr = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 1) << 5) |
                   ($urandom_range(0, WPL - 1) << 2) | $urandom_range(0, 3);
            access_chk("rnd", op != 2, op >= 2, addr, $urandom, 4'($urandom_range(0, 15)),
                       int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
